// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer
// Purpose  : Initiator for register-file x/y reads and z write-back, with the
//            ALU handoff in between. Optional REGSEQ_TIMEOUT_EN bounds the ALU
//            wait to `timeout` cycles and reports an abort on err.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
  parameter int w     = 8,
  parameter int sel_w = 4
`ifdef REGSEQ_TIMEOUT_EN
  ,
  parameter int timeout = 15
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [sel_w-1:0] cmd_x_sel,
  input  logic [sel_w-1:0] cmd_y_sel,
  input  logic [sel_w-1:0] cmd_z_sel,
  input  logic             cmd_use_y,
  input  logic             cmd_write,
  output logic [sel_w-1:0] x_sel,
  output logic [sel_w-1:0] y_sel,
  output logic [sel_w-1:0] z_sel,
  output logic             x_enb,
  output logic             y_enb,
  output logic             z_enb,
  input  logic [w-1:0]     x_in,
  input  logic [w-1:0]     y_in,
  output logic [w-1:0]     z_out,
  output logic [w-1:0]     a_out,
  output logic [w-1:0]     b_out,
  output logic             op_valid,
  input  logic [w-1:0]     res_in,
  input  logic             res_valid,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WSTB  = 3'd4,
    S_WHOLD = 3'd5
  } state_t;

  state_t r_state;
  logic   r_use_y;
  logic   r_write;

`ifdef REGSEQ_TIMEOUT_EN
  localparam int                 c_cnt_w    = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(timeout - 1);
  logic [c_cnt_w-1:0] r_cnt;
`endif

  assign cmd_ready = (r_state == S_IDLE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_use_y  <= 1'b0;
      r_write  <= 1'b0;
      x_sel    <= '0;
      y_sel    <= '0;
      z_sel    <= '0;
      x_enb    <= 1'b0;
      y_enb    <= 1'b0;
      z_enb    <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      z_out    <= '0;
      op_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef REGSEQ_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            x_sel   <= cmd_x_sel;
            y_sel   <= cmd_y_sel;
            z_sel   <= cmd_z_sel;
            r_use_y <= cmd_use_y;
            r_write <= cmd_write;
            x_enb   <= 1'b1;
            y_enb   <= cmd_use_y;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Read data is sampled on the edge that ends the strobe cycle, so
          // the operands are already presented while in CAPT.
          x_enb   <= 1'b0;
          y_enb   <= 1'b0;
          a_out   <= x_in;
          b_out   <= r_use_y ? y_in : '0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          op_valid <= 1'b1;
`ifdef REGSEQ_TIMEOUT_EN
          r_cnt    <= '0;
`endif
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (res_valid) begin
            z_out    <= res_in;
            op_valid <= 1'b0;
            if (r_write) begin
              z_enb   <= 1'b1;
              r_state <= S_WSTB;
            end else begin
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
`ifdef REGSEQ_TIMEOUT_EN
          else if (r_cnt == c_cnt_last) begin
            op_valid <= 1'b0;
            err      <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
`endif
        end
        S_WSTB: begin
          // z_sel/z_out stay put through WHOLD to give the hold window.
          z_enb   <= 1'b0;
          done    <= 1'b1;
          r_state <= S_WHOLD;
        end
        S_WHOLD: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sequencer
// Purpose  : Self-checking bench for regfile_sequencer against a cycle-level
//            reference derived from the operation timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_x_sel, cmd_y_sel, cmd_z_sel;
  logic       cmd_use_y, cmd_write;
  logic [3:0] x_sel, y_sel, z_sel;
  logic       x_enb, y_enb, z_enb;
  logic [7:0] x_in, y_in, z_out, a_out, b_out, res_in;
  logic       op_valid, res_valid, done, err;

  int checks = 0;
  int errors = 0;

  regfile_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x_sel (cmd_x_sel),
    .cmd_y_sel (cmd_y_sel),
    .cmd_z_sel (cmd_z_sel),
    .cmd_use_y (cmd_use_y),
    .cmd_write (cmd_write),
    .x_sel     (x_sel),
    .y_sel     (y_sel),
    .z_sel     (z_sel),
    .x_enb     (x_enb),
    .y_enb     (y_enb),
    .z_enb     (z_enb),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_out     (z_out),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_valid  (op_valid),
    .res_in    (res_in),
    .res_valid (res_valid),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Register file model: takes a write on the rising z strobe.
  bit [7:0]  rf [16];
  bit [15:0] rf_wr;
  always @(posedge z_enb) begin
    rf[z_sel]    <= z_out;
    rf_wr[z_sel] <= 1'b1;
  end
  assign x_in = rf_wr[x_sel] ? rf[x_sel] : init_val(int'(x_sel));
  assign y_in = rf_wr[y_sel] ? rf[y_sel] : init_val(int'(y_sel));

  logic [7:0] ref_rf [16];

  // One complete operation; called at #1 inside a cycle where the
  // sequencer should be (or soon become) ready.
  task automatic run_op(input logic [3:0] xs, input logic [3:0] ys, input logic [3:0] zs,
                        input logic uy, input logic wr, input int k,
                        input logic [7:0] res, input bit noise, output int waited);
    logic [7:0] ea, eb;
    logic [6:0] exp_f, got_f;
    int last;
    ea = ref_rf[xs];
    eb = uy ? ref_rf[ys] : 8'h00;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_x_sel = xs; cmd_y_sel = ys; cmd_z_sel = zs;
    cmd_use_y = uy; cmd_write = wr;
    @(posedge clock); #1;
    last = wr ? 6 + k : 4 + k;
    for (int c = 1; c <= last; c++) begin
      if (noise && c < last) begin
        cmd_valid = 1'($urandom); cmd_x_sel = 4'($urandom); cmd_y_sel = 4'($urandom);
        cmd_z_sel = 4'($urandom); cmd_use_y = 1'($urandom); cmd_write = 1'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      res_valid = (c == 3 + k) ? 1'b1 : (c < 3 ? 1'($urandom) : 1'b0);
      res_in    = (c == 3 + k) ? res : 8'($urandom);
      exp_f = {c == 1, (c == 1) && uy, wr && (c == 4 + k), (c >= 3) && (c <= 3 + k),
               (!wr && c == 4 + k) || (wr && c == 5 + k), c == last, 1'b0};
      got_f = {x_enb, y_enb, z_enb, op_valid, done, cmd_ready, err};
      checks++;
      if (got_f !== exp_f) begin
        errors++;
        $display("FAIL ctrl cyc%0d: {xe,ye,ze,opv,done,rdy,err}=%b required %b", c, got_f, exp_f);
      end
      checks++;
      if ({x_sel, y_sel, z_sel} !== {xs, ys, zs}) begin
        errors++;
        $display("FAIL sels cyc%0d: %h/%h/%h required %h/%h/%h", c, x_sel, y_sel, z_sel, xs, ys, zs);
      end
      if (c >= 2) begin
        checks++;
        if ({a_out, b_out} !== {ea, eb}) begin
          errors++;
          $display("FAIL operands cyc%0d: a=%h b=%h required a=%h b=%h", c, a_out, b_out, ea, eb);
        end
      end
      if (c >= 4 + k) begin
        checks++;
        if (z_out !== res) begin
          errors++;
          $display("FAIL z_out cyc%0d: %h required %h", c, z_out, res);
        end
      end
      if (c < last) begin
        @(posedge clock); #1;
      end
    end
    res_valid = 1'b0;
    if (wr) ref_rf[zs] = res;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({cmd_ready, x_enb, y_enb, z_enb, op_valid, done, err, x_sel, y_sel, z_sel,
         a_out, b_out, z_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b strobes=%b%b%b opv=%b done=%b err=%b a=%h b=%h z=%h required all 0",
               cmd_ready, x_enb, y_enb, z_enb, op_valid, done, err, a_out, b_out, z_out);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int wt;
    run_op(4'd1, 4'd2, 4'd5, 1'b0, 1'b1, 0, 8'h12, 1'b0, wt);
    run_op(4'd1, 4'd2, 4'd6, 1'b0, 1'b1, 0, 8'h34, 1'b0, wt);
    run_op(4'd5, 4'd6, 4'd7, 1'b1, 1'b1, 0, 8'h46, 1'b0, wt);
    checks++;
    if ({a_out, b_out, z_sel, z_out} !== {8'h12, 8'h34, 4'd7, 8'h46}) begin
      errors++;
      $display("FAIL basic_result: a=%h b=%h zsel=%h z=%h required 12 34 7 46", a_out, b_out, z_sel, z_out);
    end
  endtask

  task automatic test_no_y();
    int wt;
    run_op(4'd3, 4'd9, 4'd10, 1'b0, 1'b0, 0, 8'hA5, 1'b0, wt);
  endtask

  task automatic test_delay_noise();
    int wt;
    run_op(4'd7, 4'd5, 4'd11, 1'b1, 1'b1, 5, 8'h3C, 1'b1, wt);
  endtask

  task automatic test_back_to_back();
    int wt;
    int stalls;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(4'(i + 8), 4'(i + 9), 4'(i + 12), 1'b1, 1'(i % 2), 0, 8'(8'h60 + i), 1'b0, wt);
      stalls += wt;
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL back_to_back_stalls: %0d required 0", stalls);
    end
  endtask

  task automatic test_reset_in_wstb();
    logic [3:0] zs;
    zs = 4'd14;
    cmd_valid = 1'b1; cmd_x_sel = 4'd2; cmd_y_sel = 4'd3; cmd_z_sel = zs;
    cmd_use_y = 1'b1; cmd_write = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    res_valid = 1'b1; res_in = 8'hE7;
    @(posedge clock); #1;
    res_valid = 1'b0;
    checks++;
    if (z_enb !== 1'b1) begin
      errors++;
      $display("FAIL wstb_entry: z_enb=%b required 1", z_enb);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({z_enb, done, op_valid, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL wstb_async_reset: {ze,done,opv,rdy}=%b required 0000", {z_enb, done, op_valid, cmd_ready});
    end
    ref_rf[zs] = 8'hE7;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checks++;
      if ({done, cmd_ready} !== 2'b01) begin
        errors++;
        $display("FAIL wstb_after_reset cyc%0d: {done,rdy}=%b required 01", c, {done, cmd_ready});
      end
    end
  endtask

  task automatic test_random();
    int wt;
    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom), wt);
    end
  endtask

`ifdef REGSEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [6:0] exp_f, got_f;
    cmd_valid = 1'b1; cmd_x_sel = 4'd1; cmd_y_sel = 4'd2; cmd_z_sel = 4'd3;
    cmd_use_y = 1'b1; cmd_write = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      exp_f = {c == 1, c == 1, 1'b0, (c >= 3) && (c <= 17), 1'b0, c == 18, c == 18};
      got_f = {x_enb, y_enb, z_enb, op_valid, done, cmd_ready, err};
      checks++;
      if (got_f !== exp_f) begin
        errors++;
        $display("FAIL timeout cyc%0d: {xe,ye,ze,opv,done,rdy,err}=%b required %b", c, got_f, exp_f);
      end
      if (c < 18) begin
        @(posedge clock); #1;
      end
    end
  endtask
`else
  task automatic test_long_wait();
    int wt;
    run_op(4'd4, 4'd8, 4'd9, 1'b1, 1'b1, 40, 8'h5A, 1'b1, wt);
  endtask
`endif

  task automatic test_readback();
    logic [7:0] got;
    for (int i = 0; i < 16; i++) begin
      got = rf_wr[i] ? rf[i] : init_val(i);
      checks++;
      if (got !== ref_rf[i]) begin
        errors++;
        $display("FAIL regfile_contents r%0d: %h required %h", i, got, ref_rf[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_rf[i] = init_val(i);
    reset = 1'b1; cmd_valid = 1'b0; cmd_x_sel = '0; cmd_y_sel = '0; cmd_z_sel = '0;
    cmd_use_y = 1'b0; cmd_write = 1'b0; res_valid = 1'b0; res_in = '0;
    test_reset();
    test_basic();
    test_no_y();
    test_delay_noise();
    test_back_to_back();
    test_reset_in_wstb();
    test_random();
`ifdef REGSEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
